// File: rtl/sd_clock_pkg.sv
// Shared definitions for the SD clock divider / monitor pair: monitor FSM states
// and the default synchronizer depth, counter width and timeout figures.
package sd_clock_pkg;

  typedef enum logic [1:0] {
    ACQUIRE,
    MEASURE,
    LOCKED,
    LOST
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 32;
  localparam int TIMEOUT_DEF     = 150_000_000;
  localparam int JITTER_TOL_DEF  = 4;

endpackage

// File: rtl/sd_sync_edge.sv
// Synchronizes the slow SD clock into the clk domain and flags its edges.
// Strobes are gated off until the chain and level register hold real samples.
module sd_sync_edge
  import sd_clock_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_clk,
  output logic rise,
  output logic fall
);

  localparam int MASK_W = $clog2(SYNC_STAGES + 2);
  localparam logic [MASK_W-1:0] MASK_LEN = MASK_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level;
  logic [MASK_W-1:0]      mask_cnt;
  logic                   armed;

  assign armed = (mask_cnt == MASK_LEN);

  // NOTE: every register here is written with <= so the chain shifts one stage per clk.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync     <= '0;
      level    <= 1'b0;
      mask_cnt <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], in_clk};
      level <= sync[SYNC_STAGES-1];
      if (!armed) mask_cnt <= mask_cnt + MASK_W'(1);
    end
  end

  // Level tracks the input during the mask, so a high input at release is not an edge.
  assign rise = armed &  sync[SYNC_STAGES-1] & ~level;
  assign fall = armed & ~sync[SYNC_STAGES-1] &  level;

endmodule

// File: rtl/sd_clock_monitor.sv
// Slow SD clock monitor: edge strobes, high/low/period measurement, lock and loss status.
// Optional period jitter check is built when SD_CLOCK_MONITOR_JITTER_EN is defined.
module sd_clock_monitor
  import sd_clock_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int JITTER_TOL  = JITTER_TOL_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] low_cycles,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             locked,
  output logic             clk_lost,
  output logic             jitter_err
);

  if (SYNC_STAGES < 2 || JITTER_TOL < 0) begin : g_bad_param
    $error("sd_clock_monitor: SYNC_STAGES must be >= 2 and JITTER_TOL >= 0");
  end

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  logic             rise, fall;
  state_t           state;
  logic [CNT_W-1:0] run_cnt, idle_cnt, idle_nxt, high_stage, new_period;
  logic             have_rise, have_high, meas_fire, timeout;

  sd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .in_clk (in_clk),
    .rise   (rise),
    .fall   (fall)
  );

  assign idle_nxt   = (rise | fall) ? '0 : sat_inc(idle_cnt);
  assign timeout    = (idle_nxt == TIMEOUT_C);
  assign meas_fire  = rise & have_high;
  assign new_period = sat_add(high_stage, run_cnt);

  // run_cnt is the length of the phase that the current strobe terminates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      meas_valid  <= 1'b0;
      run_cnt     <= '0;
      idle_cnt    <= '0;
      high_stage  <= '0;
      have_rise   <= 1'b0;
      have_high   <= 1'b0;
      high_cycles <= '0;
      low_cycles  <= '0;
      period      <= '0;
    end else begin
      rise_pulse <= rise;
      fall_pulse <= fall;
      meas_valid <= meas_fire;
      run_cnt    <= (rise | fall) ? CNT_ONE : sat_inc(run_cnt);
      idle_cnt   <= idle_nxt;
      if (timeout) begin
        have_rise <= 1'b0;
        have_high <= 1'b0;
      end else if (rise) begin
        have_rise <= 1'b1;
        have_high <= 1'b0;
      end else if (fall && have_rise) begin
        high_stage <= run_cnt;
        have_high  <= 1'b1;
      end
      if (meas_fire) begin
        high_cycles <= high_stage;
        low_cycles  <= run_cnt;
        period      <= new_period;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ACQUIRE;
      locked   <= 1'b0;
      clk_lost <= 1'b0;
    end else if (timeout) begin
      state    <= LOST;
      locked   <= 1'b0;
      clk_lost <= 1'b1;
    end else begin
      case (state)
        ACQUIRE: if (rise) state <= MEASURE;
        MEASURE: if (meas_fire) begin
          state    <= LOCKED;
          locked   <= 1'b1;
          clk_lost <= 1'b0;
        end
        LOCKED:  state <= LOCKED;
        LOST:    if (rise) state <= MEASURE;
        default: state <= ACQUIRE;
      endcase
    end
  end

`ifdef SD_CLOCK_MONITOR_JITTER_EN
  localparam logic [CNT_W-1:0] JIT_TOL = CNT_W'(JITTER_TOL);
  logic [CNT_W-1:0] period_diff;

  // The period output still holds the previous measurement when the new one fires.
  assign period_diff = (new_period >= period) ? new_period - period : period - new_period;

  always_ff @(posedge clk) begin
    if (!reset_n) jitter_err <= 1'b0;
    else          jitter_err <= meas_fire && (state == LOCKED) && (period_diff > JIT_TOL);
  end
`else
  assign jitter_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_clock_monitor.sv
// Directed bench for sd_clock_monitor: table-driven waveform rows plus hand sequences
// for reset masking, strobe latency, timeout/recovery, mid-period reset and jitter.
module tb_sd_clock_monitor;
  import sd_clock_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 32;
  localparam int TIMEOUT     = 300;
  localparam int JITTER_TOL  = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_clk = 1'b1;
  logic             rise_pulse, fall_pulse, meas_valid, locked, clk_lost, jitter_err;
  logic [CNT_W-1:0] high_cycles, low_cycles, period;

  sd_clock_monitor #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .JITTER_TOL (JITTER_TOL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_clk     (in_clk),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .high_cycles(high_cycles),
    .low_cycles (low_cycles),
    .period     (period),
    .meas_valid (meas_valid),
    .locked     (locked),
    .clk_lost   (clk_lost),
    .jitter_err (jitter_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   hi;
    int   lo;
    int   n;
    int   exp_meas;
    int   exp_high;
    int   exp_low;
    int   exp_per;
    logic exp_locked;
  } row_t;

  row_t rows[4];

  int n_cmp = 0;
  int n_bad = 0;
  int n_meas = 0;
  int n_jit = 0;
  int m_hi = 0;       // length of the last driven high phase
  int m_lo = 0;       // length of the last driven low phase
  int last_per = 0;   // period reported by the previous meas_valid
  bit m_locked = 0;   // model: monitor is in LOCKED before the next measurement

  task automatic check(input string name, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive in_clk for the next edge, take the edge, sample 1 time unit later.
  task automatic step(input logic ic);
    in_clk = ic;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise"},   rise_pulse,  0);
    check({tag, "_fall"},   fall_pulse,  0);
    check({tag, "_meas"},   meas_valid,  0);
    check({tag, "_locked"}, locked,      0);
    check({tag, "_lost"},   clk_lost,    0);
    check({tag, "_jit"},    jitter_err,  0);
    check({tag, "_high"},   high_cycles, 0);
    check({tag, "_low"},    low_cycles,  0);
    check({tag, "_period"}, period,      0);
    check({tag, "_state"},  32'(dut.state), 32'(ACQUIRE));
  endtask

  // One constant-level phase; strobes are expected SYNC_STAGES+1 samples after a change.
  task automatic phase(input logic lvl, input int len);
    logic edge_seen;
    logic exp_jit;
    int   d;
    edge_seen = (lvl != in_clk);
    for (int i = 0; i < len; i++) begin
      step(lvl);
      check("rise_pulse", rise_pulse, lvl && edge_seen && (i == SYNC_STAGES));
      check("fall_pulse", fall_pulse, !lvl && edge_seen && (i == SYNC_STAGES));
      if (jitter_err) n_jit++;
      if (meas_valid) begin
        n_meas++;
        check("meas_with_rise", rise_pulse, 1);
        check("meas_high",   high_cycles, m_hi);
        check("meas_low",    low_cycles,  m_lo);
        check("meas_period", period,      m_hi + m_lo);
        check("meas_locked", locked,      1);
        check("meas_lost",   clk_lost,    0);
        exp_jit = 1'b0;
`ifdef SD_CLOCK_MONITOR_JITTER_EN
        d = m_hi + m_lo - last_per;
        if (d < 0) d = -d;
        exp_jit = m_locked && (d > JITTER_TOL);
`endif
        check("meas_jitter", jitter_err, exp_jit);
        last_per = m_hi + m_lo;
        m_locked = 1;
      end else begin
        check("jitter_idle", jitter_err, 0);
      end
    end
    if (lvl) m_hi = edge_seen ? len : m_hi + len;
    else     m_lo = edge_seen ? len : m_lo + len;
  endtask

  task automatic apply_row(input row_t r, input string tag);
    n_meas = 0;
    for (int p = 0; p < r.n; p++) begin
      phase(1'b1, r.hi);
      phase(1'b0, r.lo);
    end
    check({tag, "_meas_count"}, n_meas, r.exp_meas);
    check({tag, "_high"},   high_cycles, r.exp_high);
    check({tag, "_low"},    low_cycles,  r.exp_low);
    check({tag, "_period"}, period,      r.exp_per);
    check({tag, "_locked"}, locked,      r.exp_locked);
  endtask

  initial begin
    int jit_lo[8];
    int exp_jit_cnt;

    rows[0] = '{50, 50, 4, 3, 50, 50, 100, 1'b1};
    rows[1] = '{30, 70, 3, 3, 30, 70, 100, 1'b1};
    rows[2] = '{50, 50, 2, 2, 50, 50, 100, 1'b1};
    rows[3] = '{50, 50, 2, 1, 50, 50, 100, 1'b1};
    jit_lo  = '{50, 56, 50, 56, 50, 53, 50, 53};

    // Reset with in_clk high, then release: no rise, everything idle.
    reset_n = 1'b0;
    step(1'b1);
    step(1'b1);
    check_all_zero("reset");
    reset_n = 1'b1;
    phase(1'b1, 20);
    check_all_zero("post_release");

    // First fall arrives in ACQUIRE and must not start a measurement.
    phase(1'b0, 50);
    check("acq_fall_meas", n_meas, 0);
    check("acq_state", 32'(dut.state), 32'(ACQUIRE));

    for (int r = 0; r < 2; r++) apply_row(rows[r], $sformatf("row%0d", r));

    // Freeze high after a rise: loss exactly TIMEOUT cycles after that strobe.
    phase(1'b1, 3);
    for (int k = 3; k <= TIMEOUT + 2; k++) begin
      step(1'b1);
      if (k == TIMEOUT + 1) begin
        check("pre_timeout_lost",   clk_lost, 0);
        check("pre_timeout_locked", locked,   1);
      end
      if (k == TIMEOUT + 2) begin
        check("timeout_lost",   clk_lost, 1);
        check("timeout_locked", locked,   0);
        check("timeout_state",  32'(dut.state), 32'(LOST));
      end
    end
    m_locked = 0;

    // Resume: clk_lost stays up through MEASURE until the next measurement.
    n_meas = 0;
    phase(1'b1, 50);
    phase(1'b0, 50);
    phase(1'b1, 10);
    check("resume_state",  32'(dut.state), 32'(MEASURE));
    check("resume_lost",   clk_lost, 1);
    check("resume_locked", locked,   0);
    check("resume_meas",   n_meas,   0);
    phase(1'b1, 40);
    phase(1'b0, 50);
    apply_row(rows[2], "relock");

    // Reset pulse in the middle of a high phase.
    phase(1'b1, 20);
    reset_n = 1'b0;
    step(1'b1);
    check_all_zero("mid_reset");
    reset_n = 1'b1;
    m_locked = 0;
    n_meas = 0;
    phase(1'b1, 30);
    phase(1'b0, 50);
    check("mid_reset_meas",   n_meas, 0);
    check("mid_reset_locked", locked, 0);
    apply_row(rows[3], "fresh_lock");

    // Alternating 100/106 periods flag jitter; 100/103 periods stay inside tolerance.
    n_jit = 0;
    for (int p = 0; p < 8; p++) begin
      phase(1'b1, 50);
      phase(1'b0, jit_lo[p]);
    end
    phase(1'b1, 5);
`ifdef SD_CLOCK_MONITOR_JITTER_EN
    exp_jit_cnt = 4;
`else
    exp_jit_cnt = 0;
`endif
    check("jitter_count", n_jit, exp_jit_cnt);
    check("jitter_locked", locked, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
